// File: rtl/range_frame_sequencer_if.sv
// Bundle of the sample-source handshake and the range-finder burst outputs.
// The master side is the sample source / observer; the slave side is the sequencer.
interface range_frame_sequencer_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             frame_drop;
  logic [7:0]       frame_count;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, data_out, go, finish, busy, frame_drop, frame_count
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, data_out, go, finish, busy, frame_drop, frame_count
  );
endinterface

// File: rtl/range_frame_sequencer.sv
// Buffers one complete valid/ready frame, then replays it as a gap-free
// go/finish burst for the range finder. Frames of one sample or longer than
// DEPTH are dropped with a one-cycle frame_drop pulse.
module range_frame_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input logic clock,
  input logic reset,
  range_frame_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    BURST   = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    wr_cnt, wr_cnt_nxt;
  logic [CW-1:0]    n_len, n_len_nxt;
  logic [IW-1:0]    rd_idx, rd_idx_nxt;
  logic [IW-1:0]    rd_idx_inc;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             go_q, go_nxt;
  logic             finish_q, finish_nxt;
  logic             drop_q, drop_nxt;
  logic [7:0]       count_q, count_nxt;
  logic             accept;
  logic             store;
  logic [WIDTH-1:0] mem [DEPTH];

  assign accept     = bus.in_valid && ((state == FILL) || (state == DISCARD));
  assign store      = accept && (state == FILL) && (wr_cnt < CW'(DEPTH));
  assign rd_idx_inc = rd_idx + IW'(1);

  // Frame buffer write port; contents need no reset.
  always_ff @(posedge clock) begin
    if (store) begin
      mem[wr_cnt[IW-1:0]] <= bus.in_data;
    end
  end

  // State and registered-output update; reset clears everything asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      wr_cnt   <= '0;
      n_len    <= '0;
      rd_idx   <= '0;
      data_q   <= '0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      drop_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state    <= state_nxt;
      wr_cnt   <= wr_cnt_nxt;
      n_len    <= n_len_nxt;
      rd_idx   <= rd_idx_nxt;
      data_q   <= data_nxt;
      go_q     <= go_nxt;
      finish_q <= finish_nxt;
      drop_q   <= drop_nxt;
      count_q  <= count_nxt;
    end
  end

  // Next-state logic and next values of the registered burst outputs.
  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    n_len_nxt  = n_len;
    rd_idx_nxt = rd_idx;
    count_nxt  = count_q;
    data_nxt   = '0;
    go_nxt     = 1'b0;
    finish_nxt = 1'b0;
    drop_nxt   = 1'b0;

    case (state)
      FILL: begin
        if (accept) begin
          if (wr_cnt < CW'(DEPTH)) begin
            wr_cnt_nxt = wr_cnt + CW'(1);
            if (bus.in_last) begin
              if (wr_cnt >= CW'(1)) begin
                // Load the first beat now so go/data are registered at burst start.
                state_nxt  = BURST;
                n_len_nxt  = wr_cnt + CW'(1);
                rd_idx_nxt = '0;
                data_nxt   = mem[0];
                go_nxt     = 1'b1;
              end else begin
                drop_nxt   = 1'b1;
                wr_cnt_nxt = '0;
              end
            end else begin
              state_nxt = FILL;
            end
          end else begin
            // Oversize frame: the extra sample is thrown away.
            wr_cnt_nxt = '0;
            if (bus.in_last) begin
              drop_nxt = 1'b1;
            end else begin
              state_nxt = DISCARD;
            end
          end
        end else begin
          state_nxt = FILL;
        end
      end

      DISCARD: begin
        if (accept && bus.in_last) begin
          drop_nxt  = 1'b1;
          state_nxt = FILL;
        end else begin
          state_nxt = DISCARD;
        end
      end

      BURST: begin
        if (CW'(rd_idx) == (n_len - CW'(1))) begin
          state_nxt  = GAP;
          count_nxt  = count_q + 8'd1;
          wr_cnt_nxt = '0;
          rd_idx_nxt = '0;
        end else begin
          rd_idx_nxt = rd_idx_inc;
          data_nxt   = mem[rd_idx_inc];
          finish_nxt = (CW'(rd_idx_inc) == (n_len - CW'(1)));
        end
      end

      GAP: begin
        state_nxt = FILL;
      end

      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  assign bus.in_ready    = (state == FILL) || (state == DISCARD);
  assign bus.busy        = (state == BURST) || (state == GAP);
  assign bus.data_out    = data_q;
  assign bus.go          = go_q;
  assign bus.finish      = finish_q;
  assign bus.frame_drop  = drop_q;
  assign bus.frame_count = count_q;
endmodule

// File: tb/tb_range_frame_sequencer.sv
// Self-checking bench: a frame-level reference model predicts every output
// each cycle; directed frames from the test plan plus random frames.
module tb_range_frame_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic             go;
    logic             fin;
    logic [WIDTH-1:0] d;
  } beat_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  range_frame_sequencer_if #(.WIDTH(WIDTH)) bus ();

  range_frame_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state: pending burst+gap cycles, frame being collected.
  beat_t            sched[$];
  logic [WIDTH-1:0] frm[$];
  bit               over;
  bit               m_drop;
  int               m_count;
  logic [WIDTH-1:0] stim [32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One model step per clock edge (or reset assertion).
  task automatic model_step();
    bit was_ready;
    if (reset) begin
      sched.delete();
      frm.delete();
      over    = 1'b0;
      m_drop  = 1'b0;
      m_count = 0;
    end else begin
      was_ready = (sched.size() == 0);
      m_drop    = 1'b0;
      if (!was_ready) begin
        if (sched[0].fin) m_count = (m_count + 1) % 256;
        void'(sched.pop_front());
      end
      if (was_ready && bus.in_valid) begin
        if (over) begin
          if (bus.in_last) begin
            over   = 1'b0;
            m_drop = 1'b1;
          end
        end else begin
          frm.push_back(bus.in_data);
          if (bus.in_last) begin
            if (frm.size() == 1 || frm.size() > DEPTH) begin
              m_drop = 1'b1;
            end else begin
              for (int i = 0; i < frm.size(); i++)
                sched.push_back('{go: (i == 0), fin: (i == frm.size() - 1), d: frm[i]});
              sched.push_back('{go: 1'b0, fin: 1'b0, d: '0});
            end
            frm.delete();
          end else if (frm.size() > DEPTH) begin
            over = 1'b1;
            frm.delete();
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (sched.size() > 0) begin
          check_eq("in_ready", 32'(bus.in_ready), 32'd0);
          check_eq("busy", 32'(bus.busy), 32'd1);
          check_eq("go", 32'(bus.go), 32'(sched[0].go));
          check_eq("finish", 32'(bus.finish), 32'(sched[0].fin));
          check_eq("data_out", 32'(bus.data_out), 32'(sched[0].d));
        end else begin
          check_eq("in_ready", 32'(bus.in_ready), 32'd1);
          check_eq("busy", 32'(bus.busy), 32'd0);
          check_eq("go", 32'(bus.go), 32'd0);
          check_eq("finish", 32'(bus.finish), 32'd0);
          check_eq("data_out", 32'(bus.data_out), 32'd0);
        end
        check_eq("frame_drop", 32'(bus.frame_drop), 32'(m_drop));
        check_eq("frame_count", 32'(bus.frame_count), 32'(m_count));
      end
    end
  end

  task automatic wait_accept();
    int t = 0;
    bit ok = 1'b0;
    while (!ok && t < 100) begin
      ok = bus.in_ready;
      @(negedge clock);
      t++;
    end
    if (!ok) check_eq("accept_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  // mode 0: continuous valid, 1: bubble before every sample after the first, 2: random bubbles.
  task automatic send_frame(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom_range(0, 1));
        bus.in_data  = WIDTH'($urandom);
        @(negedge clock);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      bus.in_last  = (i == n - 1);
      wait_accept();
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_go", 32'(bus.go), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_count", 32'(bus.frame_count), 32'd0);
    check_eq("rst_data", 32'(bus.data_out), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_ready", 32'(bus.in_ready), 32'd1);

    // Frame 5,9,2,7 continuous, then with bubbles.
    stim[0] = 16'd5; stim[1] = 16'd9; stim[2] = 16'd2; stim[3] = 16'd7;
    send_frame(4, 0);
    idle(8);
    check_eq("count_f1", 32'(bus.frame_count), 32'd1);
    send_frame(4, 1);
    idle(8);
    check_eq("count_f2", 32'(bus.frame_count), 32'd2);

    // Single-sample frame is dropped.
    stim[0] = 16'd42;
    send_frame(1, 0);
    idle(3);
    check_eq("count_single", 32'(bus.frame_count), 32'd2);

    // Oversize 17-sample frame, then 1,2,3, then a full 16-sample frame.
    for (int i = 0; i < 17; i++) stim[i] = WIDTH'(100 + i);
    send_frame(17, 0);
    idle(3);
    check_eq("count_oversize", 32'(bus.frame_count), 32'd2);
    stim[0] = 16'd1; stim[1] = 16'd2; stim[2] = 16'd3;
    send_frame(3, 0);
    idle(6);
    check_eq("count_3", 32'(bus.frame_count), 32'd3);
    for (int i = 0; i < 16; i++) stim[i] = WIDTH'(16'hA000 + i);
    send_frame(16, 0);
    idle(20);
    check_eq("count_16", 32'(bus.frame_count), 32'd4);

    // Back-to-back frames with valid held high.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) stim[i] = WIDTH'(16'h0100 * (f + 1) + i);
      send_frame(4, 0);
    end
    idle(10);
    check_eq("count_b2b", 32'(bus.frame_count), 32'd7);

    // Random frames, lengths including drop cases.
    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) stim[i] = WIDTH'($urandom);
      send_frame(n, 2);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(25);

    // Reset in the middle of a 6-beat burst.
    for (int i = 0; i < 6; i++) stim[i] = WIDTH'(16'h0600 + i);
    send_frame(6, 0);
    idle(2);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_go", 32'(bus.go), 32'd0);
    check_eq("mid_rst_finish", 32'(bus.finish), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_data", 32'(bus.data_out), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check_eq("post_rst_count", 32'(bus.frame_count), 32'd0);
    stim[0] = 16'hBEEF; stim[1] = 16'hCAFE;
    send_frame(2, 0);
    idle(6);
    check_eq("post_rst_frame", 32'(bus.frame_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
